// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared widths and helpers for the UART receive buffer
package uart_rx_fifo_pkg;
  localparam int UART_BYTE_W = 8;
  localparam int ERR_CNT_W = 8;
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: generic first-word-fall-through FIFO with occupancy count
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_48,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level
);
  localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok;
  assign empty = level == '0;
  assign full = level == DEPTH;
  assign rd_ok = rd_en & ~empty;
  // a full FIFO still accepts a write when the head leaves in the same cycle
  assign wr_ok = wr_en & (~full | rd_ok);
  assign rd_data = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk_48)
    if (wr_ok) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk_48 or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok != rd_ok) level <= wr_ok ? level + 1'b1 : level - 1'b1;
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: buffers UART receive strobes, tracks overflow and frame errors
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter bit DROP_FRAME_ERRORS = 1'b1
) (
  input  logic                   clk_48,
  input  logic                   rst_n,
  input  logic [UART_BYTE_W-1:0] in_data,
  input  logic                   in_valid,
  input  logic                   in_frame_error,
  output logic [UART_BYTE_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DEPTH_LOG2:0]    level,
  output logic                   overflow,
  output logic [ERR_CNT_W-1:0]   frame_err_cnt,
  input  logic                   clear_errors
);
  logic empty, full, keep, pop, push, frame_err;
  assign pop = out_valid & out_ready;
  assign frame_err = in_valid & in_frame_error;
  assign keep = in_valid & ~(in_frame_error & DROP_FRAME_ERRORS);
  assign push = keep & (~full | pop);
  assign out_valid = ~empty;
  sync_fifo_fwft #(.WIDTH(UART_BYTE_W), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk_48 (clk_48),
    .rst_n  (rst_n),
    .wr_en  (push),
    .wr_data(in_data),
    .rd_en  (pop),
    .rd_data(out_data),
    .empty  (empty),
    .full   (full),
    .level  (level)
  );
  // new events take priority over a simultaneous clear
  always_ff @(posedge clk_48 or negedge rst_n)
    if (!rst_n) begin
      overflow <= 1'b0;
      frame_err_cnt <= '0;
    end else begin
      overflow <= (keep & full & ~pop) | (overflow & ~clear_errors);
      frame_err_cnt <= frame_err ? (clear_errors ? ERR_CNT_W'(1) : sat_inc(frame_err_cnt))
                     : clear_errors ? '0 : frame_err_cnt;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed vector table plus corner-case sequences
module tb_uart_rx_fifo;
  logic clk_48 = 1'b0, rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0, in_frame_error = 1'b0, out_ready = 1'b0, clear_errors = 1'b0;
  logic [7:0] out_data, frame_err_cnt;
  logic out_valid, overflow;
  logic [4:0] level;
  int checks = 0, errors = 0;

  uart_rx_fifo #(.DEPTH_LOG2(4), .DROP_FRAME_ERRORS(1'b1)) dut (
    .clk_48(clk_48), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_frame_error(in_frame_error), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .overflow(overflow),
    .frame_err_cnt(frame_err_cnt), .clear_errors(clear_errors)
  );

  always #10 clk_48 = ~clk_48;

  typedef struct {
    logic [7:0] d; logic v, fe, rdy, clr;
    logic ev; logic [7:0] ed; logic [4:0] el; logic eo; logic [7:0] ec;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic v, fe, rdy, clr);
    in_data = d; in_valid = v; in_frame_error = fe; out_ready = rdy; clear_errors = clr;
  endtask

  task automatic step();
    @(posedge clk_48);
    @(negedge clk_48);
    drive(8'h00, 0, 0, 0, 0);
  endtask

  initial begin
    tbl[0]  = '{8'h41, 1, 0, 0, 0, 1, 8'h41, 5'd1, 0, 8'd0};
    tbl[1]  = '{8'h42, 1, 0, 0, 0, 1, 8'h41, 5'd2, 0, 8'd0};
    tbl[2]  = '{8'h43, 1, 0, 0, 0, 1, 8'h41, 5'd3, 0, 8'd0};
    tbl[3]  = '{8'h00, 0, 0, 1, 0, 1, 8'h42, 5'd2, 0, 8'd0};
    tbl[4]  = '{8'h00, 0, 0, 1, 0, 1, 8'h43, 5'd1, 0, 8'd0};
    tbl[5]  = '{8'h00, 0, 0, 1, 0, 0, 8'h00, 5'd0, 0, 8'd0};
    tbl[6]  = '{8'h00, 0, 0, 1, 0, 0, 8'h00, 5'd0, 0, 8'd0};
    tbl[7]  = '{8'h55, 1, 1, 0, 0, 0, 8'h00, 5'd0, 0, 8'd1};
    tbl[8]  = '{8'h60, 1, 1, 0, 0, 0, 8'h00, 5'd0, 0, 8'd2};
    tbl[9]  = '{8'h00, 0, 0, 0, 1, 0, 8'h00, 5'd0, 0, 8'd0};
    tbl[10] = '{8'h61, 1, 1, 0, 1, 0, 8'h00, 5'd0, 0, 8'd1};
    tbl[11] = '{8'h12, 1, 0, 0, 0, 1, 8'h12, 5'd1, 0, 8'd1};
    tbl[12] = '{8'h00, 0, 0, 1, 1, 0, 8'h00, 5'd0, 0, 8'd0};

    @(negedge clk_48);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cnt", frame_err_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk_48);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].d, tbl[i].v, tbl[i].fe, tbl[i].rdy, tbl[i].clr);
      step();
      chk($sformatf("v%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("v%0d_data", i), out_data, tbl[i].ed);
      chk($sformatf("v%0d_level", i), level, tbl[i].el);
      chk($sformatf("v%0d_ovf", i), overflow, tbl[i].eo);
      chk($sformatf("v%0d_cnt", i), frame_err_cnt, tbl[i].ec);
    end

    for (int i = 0; i < 16; i++) begin drive(8'(i), 1, 0, 0, 0); step(); end
    drive(8'h10, 1, 0, 0, 0); step();
    chk("full_ovf", overflow, 1);
    chk("full_level", level, 16);
    for (int i = 0; i < 16; i++) begin
      out_ready = 1'b1;
      chk($sformatf("drain%0d_valid", i), out_valid, 1);
      chk($sformatf("drain%0d_data", i), out_data, i);
      step();
    end
    chk("drained_valid", out_valid, 0);
    chk("drained_level", level, 0);
    chk("ovf_sticky", overflow, 1);

    drive(8'h00, 0, 0, 0, 1); step();
    chk("clr_ovf", overflow, 0);
    for (int i = 0; i < 16; i++) begin drive(8'hA0 + 8'(i), 1, 0, 0, 0); step(); end
    chk("refill_level", level, 16);
    drive(8'h99, 1, 0, 1, 0); step();
    chk("pushpop_ovf", overflow, 0);
    chk("pushpop_level", level, 16);
    for (int i = 0; i < 16; i++) begin
      out_ready = 1'b1;
      chk($sformatf("pp_drain%0d", i), out_data, i < 15 ? 8'hA1 + 8'(i) : 8'h99);
      step();
    end
    chk("pp_empty", out_valid, 0);

    for (int i = 0; i < 300; i++) begin drive(8'hE0, 1, 1, 0, 0); step(); end
    chk("sat_cnt", frame_err_cnt, 8'hFF);
    chk("sat_level", level, 0);
    chk("sat_ovf", overflow, 0);

    drive(8'h00, 0, 0, 0, 1); step();
    chk("clr_cnt", frame_err_cnt, 0);
    for (int i = 0; i < 5; i++) begin drive(8'hE1, 1, 1, 0, 0); step(); end
    for (int i = 0; i < 17; i++) begin drive(8'(i), 1, 0, 0, 0); step(); end
    chk("pre_clr_ovf", overflow, 1);
    chk("pre_clr_cnt", frame_err_cnt, 5);
    drive(8'h00, 0, 0, 0, 1); step();
    chk("clr2_ovf", overflow, 0);
    chk("clr2_cnt", frame_err_cnt, 0);
    chk("clr2_level", level, 16);
    chk("clr2_data", out_data, 0);
    drive(8'h33, 1, 1, 0, 1); step();
    chk("clr_fe_cnt", frame_err_cnt, 1);
    drive(8'h34, 1, 0, 0, 1); step();
    chk("clr_ovf_wins", overflow, 1);
    chk("clr_ovf_cnt", frame_err_cnt, 0);

    for (int i = 0; i < 9; i++) begin out_ready = 1'b1; step(); end
    chk("mid_level", level, 7);
    chk("mid_data", out_data, 9);
    #3 rst_n = 1'b0;
    #1;
    chk("async_level", level, 0);
    chk("async_valid", out_valid, 0);
    chk("async_data", out_data, 0);
    chk("async_ovf", overflow, 0);
    @(negedge clk_48);
    rst_n = 1'b1;
    drive(8'h7E, 1, 0, 0, 0); step();
    chk("post_valid", out_valid, 1);
    chk("post_data", out_data, 8'h7E);
    chk("post_level", level, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the uart block.
- Absorbs bytes from the UART receiver, which has no backpressure: its valid is a single-cycle strobe and its ready is tied high.
- Stores bytes in a first-word-fall-through FIFO and presents them to the consumer (USB/command logic) over a valid/ready handshake.
- Records overflow and framing-error statistics for status readout.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries); legal range 2..10.
- DROP_FRAME_ERRORS, 1, 1 = discard bytes flagged with a frame error; 0 = store them anyway (they are still counted).

Ports:
- clk_48  input  1  system clock, 48 MHz; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  8  received byte (from rx_data).
- in_valid  input  1  one-cycle strobe that the byte is present (from rx_data_valid).
- in_frame_error  input  1  stop-bit error for the current byte; meaningful only while in_valid=1.
- out_data  output  8  head-of-FIFO byte; forced to 8'h00 while out_valid=0.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts the head byte when out_valid & out_ready.
- level  output  DEPTH_LOG2+1  current number of stored bytes, 0..2^DEPTH_LOG2.
- overflow  output  1  sticky flag: at least one good byte was dropped because the FIFO was full.
- frame_err_cnt  output  8  saturating count of frame-error bytes received.
- clear_errors  input  1  one-cycle pulse that clears overflow and frame_err_cnt.

Behaviour:
- Reset (async assert, sync release): rd/wr pointers=0, level=0, out_valid=0, out_data=0, overflow=0, frame_err_cnt=0. Memory contents are don't-care.
- push = in_valid & ~(in_frame_error & DROP_FRAME_ERRORS) & (not full | pop).
- pop = out_valid & out_ready.
- Write latency: a byte pushed in cycle N is visible at out_data with out_valid=1 in cycle N+1. No same-cycle bypass when empty.
- First-word fall-through: out_data is the head entry whenever out_valid=1, with no extra read cycle. After a pop, the next entry (if any) appears in the following cycle.
- level update: +1 on push only, -1 on pop only, unchanged when both or neither.
- Full (level = 2^DEPTH_LOG2):
  - with pop in the same cycle, the incoming byte is accepted (no overflow);
  - without pop, the byte is dropped, pointers are unchanged and overflow sets to 1.
- Empty: out_ready is ignored; no pointer movement and no underflow.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. Full/empty derive from level, not pointer compare.
- Frame error (in_valid & in_frame_error):
  - frame_err_cnt increments, saturating at 8'hFF;
  - with DROP_FRAME_ERRORS=1 the byte is not stored and never sets overflow;
  - with DROP_FRAME_ERRORS=0 it is stored like a good byte, and is subject to the overflow rule when full.
- clear_errors: in the cycle after the pulse, overflow=0 and frame_err_cnt=0. If a new overflow or frame error occurs in the same cycle as clear_errors, the event wins: overflow=1, or frame_err_cnt=1.
- clear_errors does not affect FIFO contents or level.
- in_valid is assumed to be a strobe at ≤ 1 byte per baud interval. Back-to-back in_valid on consecutive cycles must still be handled correctly.
- Reset mid-operation: all stored bytes are lost. out_valid drops asynchronously with rst_n.

Decomposition:
- Shared constants header: UART_BYTE_W = 8, ERR_CNT_W = 8.
- One sub-module: sync_fifo_fwft (parameters WIDTH, DEPTH_LOG2; ports clk_48, rst_n, wr_en, wr_data, rd_en, rd_data, empty, full, level). It is generic and reusable for a future TX-side buffer.
- uart_rx_fifo wraps it with the push/drop filter, overflow flag and error counter.

Test Plan:
- Reset, then push 0x41, 0x42, 0x43 with out_ready=0 → level=3, out_valid=1, out_data=0x41. Raise out_ready for 3 cycles → reads 0x41, 0x42, 0x43, then out_valid=0, level=0.
- Fill 16 bytes 0x00..0x0F, push 0x10 with out_ready=0 → 0x10 dropped, overflow=1, level=16. Drain → 0x00..0x0F exactly.
- Full FIFO, push 0x99 in the same cycle as a pop → overflow stays 0, level stays 16, and 0x99 is the last byte drained.
- DROP_FRAME_ERRORS=1: push 0x55 with in_frame_error=1 → level unchanged, frame_err_cnt=1. Send 300 error bytes → frame_err_cnt=0xFF.
- clear_errors pulse with overflow=1, cnt=5, no other events → next cycle both 0. Repeat with a frame-error byte in the same cycle → cnt=1.
- Assert rst_n=0 while level=7 → out_valid=0 and level=0 immediately. After release, a new push 0x7E appears after 1 cycle.
